// File: rtl/escaneo_teclado_if.sv
// Keypad-side and calculator-side signals of the scanner, grouped so the
// scanner sees them as one bundle (master) and the keypad/calculator as the peer (slave).
interface escaneo_teclado_if;
  logic       R1;
  logic       R2;
  logic       R3;
  logic       R4;
  logic       botonApretado;
  logic       C1;
  logic       C2;
  logic       C3;
  logic       C4;
  logic       enableDeteccion;
  logic [3:0] tecla;
  logic       teclaValida;

  modport master (
    input  R1, R2, R3, R4, botonApretado,
    output C1, C2, C3, C4, enableDeteccion, tecla, teclaValida
  );

  modport slave (
    output R1, R2, R3, R4, botonApretado,
    input  C1, C2, C3, C4, enableDeteccion, tecla, teclaValida
  );
endinterface

// File: rtl/escaneo_teclado.sv
// Keypad scanner: rotates the column drive, freezes on a press, debounces it,
// emits a one-cycle key code pulse and waits for a debounced release.
module escaneo_teclado #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8
) (
  input logic         Clk,
  input logic         Reset,
  escaneo_teclado_if.master bus
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0] DEB_MAX    = DBW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } estado_t;

  estado_t        estado, estado_sig;
  logic [1:0]     col_actual, col_sig;
  logic [3:0]     col_onehot;
  logic [DW-1:0]  cuenta_dwell, dwell_sig;
  logic [DBW-1:0] cuenta_deb, deb_sig;
  logic [1:0]     fila_cap, fila_cap_sig;
  logic [1:0]     col_cap, col_cap_sig;
  logic           emitir;

  logic [3:0]     filas_meta, filas_sync;
  logic           boton_meta, boton_sync;
  logic [1:0]     fila_enc;
  logic           habilitar;
  logic [3:0]     tecla_reg;
  logic           valida_reg;

  function automatic logic [1:0] fila_prioritaria(input logic [3:0] filas);
    logic [1:0] idx;
    if (filas[0])      idx = 2'd0;
    else if (filas[1]) idx = 2'd1;
    else if (filas[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [DBW-1:0] inc_sat(input logic [DBW-1:0] v);
    return (v == DEB_MAX) ? v : v + 1'b1;
  endfunction

  // Rows and the detection flag arrive asynchronously; two flops each before use.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      filas_meta <= '0;
      filas_sync <= '0;
      boton_meta <= 1'b0;
      boton_sync <= 1'b0;
    end else begin
      filas_meta <= {bus.R4, bus.R3, bus.R2, bus.R1};
      filas_sync <= filas_meta;
      boton_meta <= bus.botonApretado;
      boton_sync <= boton_meta;
    end
  end

  assign fila_enc = fila_prioritaria(filas_sync);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado       <= ST_SCAN;
      col_actual   <= 2'd0;
      col_onehot   <= 4'b0001;
      cuenta_dwell <= '0;
      cuenta_deb   <= '0;
      fila_cap     <= 2'd0;
      col_cap      <= 2'd0;
    end else begin
      estado       <= estado_sig;
      col_actual   <= col_sig;
      col_onehot   <= 4'b0001 << col_sig;
      cuenta_dwell <= dwell_sig;
      cuenta_deb   <= deb_sig;
      fila_cap     <= fila_cap_sig;
      col_cap      <= col_cap_sig;
    end
  end

  // The debounce exit fires on the DEBOUNCE-th matching cycle itself so that
  // EMIT follows immediately and the pulse lands SCAN_DIV+DEBOUNCE+1 cycles in.
  always_comb begin
    estado_sig   = estado;
    col_sig      = col_actual;
    dwell_sig    = cuenta_dwell;
    deb_sig      = cuenta_deb;
    fila_cap_sig = fila_cap;
    col_cap_sig  = col_cap;
    emitir       = 1'b0;

    case (estado)
      ST_SCAN: begin
        if (cuenta_dwell == DWELL_LAST) begin
          dwell_sig = '0;
          if (boton_sync) begin
            fila_cap_sig = fila_enc;
            col_cap_sig  = col_actual;
            deb_sig      = '0;
            estado_sig   = ST_DEBOUNCE;
          end else begin
            col_sig = col_actual + 2'd1;
          end
        end else begin
          dwell_sig = cuenta_dwell + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if ((|filas_sync) && (fila_enc == fila_cap)) begin
          if (cuenta_deb >= DEB_LAST) begin
            deb_sig    = '0;
            estado_sig = ST_EMIT;
          end else begin
            deb_sig = inc_sat(cuenta_deb);
          end
        end else begin
          deb_sig    = '0;
          dwell_sig  = '0;
          col_sig    = col_actual + 2'd1;
          estado_sig = ST_SCAN;
        end
      end

      ST_EMIT: begin
        emitir     = 1'b1;
        deb_sig    = '0;
        estado_sig = ST_WAIT_RELEASE;
      end

      ST_WAIT_RELEASE: begin
        if (boton_sync) begin
          deb_sig = '0;
        end else if (cuenta_deb >= DEB_LAST) begin
          deb_sig    = '0;
          dwell_sig  = '0;
          col_sig    = col_actual + 2'd1;
          estado_sig = ST_SCAN;
        end else begin
          deb_sig = inc_sat(cuenta_deb);
        end
      end

      default: begin
        estado_sig = ST_SCAN;
        col_sig    = 2'd0;
        dwell_sig  = '0;
        deb_sig    = '0;
      end
    endcase
  end

  // Key code and its strobe are registered together so they change on one edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tecla_reg  <= 4'd0;
      valida_reg <= 1'b0;
    end else begin
      valida_reg <= emitir;
      if (emitir) begin
        tecla_reg <= {fila_cap, col_cap};
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      habilitar <= 1'b0;
    end else begin
      habilitar <= 1'b1;
    end
  end

  assign bus.C1              = col_onehot[0];
  assign bus.C2              = col_onehot[1];
  assign bus.C3              = col_onehot[2];
  assign bus.C4              = col_onehot[3];
  assign bus.tecla           = tecla_reg;
  assign bus.teclaValida     = valida_reg;
  assign bus.enableDeteccion = habilitar;

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: a keypad model drives the rows from the columns,
// and a timeline model predicts column, pulse and key code for every cycle.
module tb_escaneo_teclado;

  localparam int SD  = 4;
  localparam int DB  = 8;
  localparam int BIG = 1 << 30;

  logic Clk;
  logic Reset;
  escaneo_teclado_if bus();

  escaneo_teclado #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Keypad: bit r*4+c held means row r conducts whenever column c is driven.
  logic [15:0] keysDown;
  logic [3:0]  colVec;
  logic [3:0]  rowVec;

  assign colVec = {bus.C4, bus.C3, bus.C2, bus.C1};

  always_comb begin
    rowVec = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keysDown[r*4+c] && colVec[c]) rowVec[r] = 1'b1;
  end

  assign bus.R1            = rowVec[0];
  assign bus.R2            = rowVec[1];
  assign bus.R3            = rowVec[2];
  assign bus.R4            = rowVec[3];
  assign bus.botonApretado = |rowVec;

  // Timeline model: rotation from an anchor, an optional frozen interval, one pulse.
  int         anchorCyc, anchorCol;
  int         freezeFrom, freezeUntil, freezeCol;
  int         pulseAt;
  logic [3:0] pulseCode;
  logic [3:0] modelTecla;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] expTecla;
    int         hold;
  } vec_t;

  vec_t vecs[16];

  function automatic int modelCol(input int t);
    if (t < freezeFrom)       return (anchorCol + (t - anchorCyc) / SD) % 4;
    else if (t < freezeUntil) return freezeCol;
    else                      return (freezeCol + 1 + (t - freezeUntil) / SD) % 4;
  endfunction

  // First window of column c whose second cycle is at or after press cycle p.
  function automatic int nextWindow(input int c, input int p);
    int w;
    w = anchorCyc + SD * ((c - anchorCol + 4) % 4);
    while (w < p - 1) w += 4 * SD;
    return w;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic checkCycle();
    if (cyc >= freezeUntil) begin
      anchorCyc   = freezeUntil;
      anchorCol   = (freezeCol + 1) % 4;
      freezeFrom  = BIG;
      freezeUntil = BIG;
    end
    if (cyc == pulseAt) modelTecla = pulseCode;
    checkOutput("columns", int'(colVec), 1 << modelCol(cyc));
    checkOutput("teclaValida", int'(bus.teclaValida), (cyc == pulseAt) ? 1 : 0);
    checkOutput("tecla", int'(bus.tecla), int'(modelTecla));
    checkOutput("enableDeteccion", int'(bus.enableDeteccion), 1);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge Clk);
      checkCycle();
    end
  endtask

  task automatic resetDut();
    Reset    = 1'b1;
    keysDown = '0;
    #1;
    checkOutput("reset_columns", int'(colVec), 1);
    checkOutput("reset_tecla", int'(bus.tecla), 0);
    checkOutput("reset_valid", int'(bus.teclaValida), 0);
    checkOutput("reset_enable", int'(bus.enableDeteccion), 0);
    @(negedge Clk);
    checkOutput("reset_hold_columns", int'(colVec), 1);
    Reset       = 1'b0;
    anchorCyc   = cyc;
    anchorCol   = 0;
    freezeFrom  = BIG;
    freezeUntil = BIG;
    pulseAt     = BIG;
    modelTecla  = 4'd0;
    #1;
    checkOutput("enable_before_first_clock", int'(bus.enableDeteccion), 0);
  endtask

  // Press the keys in mask (all on column col), hold past the pulse, release.
  task automatic applyStimulus(input logic [15:0] mask, input int col,
                               input logic [3:0] code, input int hold);
    int s;
    s           = nextWindow(col, cyc);
    freezeFrom  = s;
    freezeCol   = col;
    freezeUntil = BIG;
    pulseAt     = s + SD + DB + 1;
    pulseCode   = code;
    keysDown    = mask;
    runCycles(pulseAt - cyc + hold);
    keysDown    = '0;
    freezeUntil = cyc + DB + 2;
    runCycles(DB + 3);
  endtask

  task automatic bounceSequence();
    int s;
    s = nextWindow(0, cyc + 2);
    runCycles(s + 1 - cyc);
    keysDown    = 16'h1000;
    freezeFrom  = s;
    freezeCol   = 0;
    freezeUntil = s + 7;
    pulseAt     = BIG;
    runCycles(3);
    keysDown = '0;
    runCycles(3);
    keysDown = 16'h1000;
    runCycles(3);
    keysDown = '0;
    runCycles(12);
  endtask

  task automatic resetMidPress();
    int s;
    s           = nextWindow(3, cyc);
    keysDown    = 16'h0008;
    freezeFrom  = s;
    freezeCol   = 3;
    freezeUntil = BIG;
    pulseAt     = BIG;
    runCycles(s + 6 - cyc);
    resetDut();
    runCycles(40);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 4'd0,  0};
    vecs[1]  = '{0, 1, 4'd1,  3};
    vecs[2]  = '{0, 2, 4'd2,  1};
    vecs[3]  = '{0, 3, 4'd3,  0};
    vecs[4]  = '{1, 0, 4'd4,  2};
    vecs[5]  = '{1, 1, 4'd5,  0};
    vecs[6]  = '{1, 3, 4'd7,  4};
    vecs[7]  = '{2, 0, 4'd8,  0};
    vecs[8]  = '{2, 1, 4'd9,  1};
    vecs[9]  = '{2, 2, 4'd10, 0};
    vecs[10] = '{2, 3, 4'd11, 2};
    vecs[11] = '{3, 1, 4'd13, 0};
    vecs[12] = '{3, 2, 4'd14, 3};
    vecs[13] = '{3, 3, 4'd15, 0};
    vecs[14] = '{1, 2, 4'd6,  1};
    vecs[15] = '{3, 0, 4'd12, 0};

    Reset       = 1'b0;
    keysDown    = '0;
    anchorCyc   = 0;
    anchorCol   = 0;
    freezeFrom  = BIG;
    freezeUntil = BIG;
    freezeCol   = 0;
    pulseAt     = BIG;
    pulseCode   = 4'd0;
    modelTecla  = 4'd0;
    #2;

    $display("[TB] reset and idle scan");
    resetDut();
    runCycles(64);

    $display("[TB] single press R2/C3 with long hold");
    applyStimulus(16'h0040, 2, 4'd6, 200);

    $display("[TB] bouncing R4/C1 then stable press");
    bounceSequence();
    applyStimulus(16'h1000, 0, 4'd12, 5);

    $display("[TB] table of all keys");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'(1 << (vecs[i].row * 4 + vecs[i].col)), vecs[i].col,
                    vecs[i].expTecla, vecs[i].hold);
    end

    $display("[TB] multi-row R1+R3 on C2");
    applyStimulus(16'h0202, 1, 4'd1, 10);

    $display("[TB] randomized presses");
    for (int n = 0; n < 12; n++) begin
      int r, r2, c, rowWin;
      logic [15:0] mask;
      r      = int'($urandom_range(0, 3));
      c      = int'($urandom_range(0, 3));
      mask   = 16'(1 << (r * 4 + c));
      rowWin = r;
      if ($urandom_range(0, 1) == 1) begin
        r2   = int'($urandom_range(0, 3));
        mask = mask | 16'(1 << (r2 * 4 + c));
        if (r2 < rowWin) rowWin = r2;
      end
      runCycles(int'($urandom_range(0, 20)));
      applyStimulus(mask, c, 4'(rowWin * 4 + c), int'($urandom_range(0, 20)));
    end

    $display("[TB] reset during debounce of R1/C4");
    resetMidPress();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
